// File: rtl/uart_pkg.sv
// Types and sizing shared by the UART TX and RX holding FIFOs.
package uart_pkg;

    localparam int unsigned UART_FIFO_DEPTH = 16;
    localparam int unsigned UART_DATA_W     = 8;

    typedef enum logic {
        FIFO_16450 = 1'b0,
        FIFO_16550 = 1'b1
    } fifo_mode_t;

    // 16450 mode collapses the FIFO to a single holding register.
    function automatic int unsigned fifo_cap(input fifo_mode_t mode, input int unsigned depth);
        return (mode == FIFO_16550) ? depth : 32'd1;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// 16550 transmit holding FIFO: FWFT head on dout, edge-detected pop, level flags
// and sticky overrun/underrun indications.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_FIFO_DEPTH,
    parameter int unsigned WIDTH = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_en,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    input  logic [$clog2(DEPTH)-1:0] thresh,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     below_thresh,
    output logic                     overrun,
    output logic                     underrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0] rptr_q, rptr_nxt;
    logic [AW-1:0] wptr_q, wptr_nxt;
    logic [LW-1:0] level_q, level_nxt;
    logic          pop_d;
    logic          overrun_nxt, underrun_nxt;

    fifo_mode_t    mode;
    logic [LW-1:0] cap;
    logic          pop_evt;
    logic          wr_ok, rd_ok;
    logic          mem_we;
    logic [WIDTH-1:0] head;

    assign mode = fifo_mode_t'(fifo_en);
    assign cap  = LW'(fifo_cap(mode, DEPTH));

    // The transmitter holds pop as a level; only its rising edge dequeues.
    assign pop_evt = pop & ~pop_d;

    assign empty        = (level_q == '0);
    assign full         = (level_q == cap);
    assign below_thresh = (level_q <= {1'b0, thresh});
    assign level        = level_q;

    // A pop edge on a full FIFO frees the slot the simultaneous push lands in.
    assign wr_ok  = push & (~full | pop_evt);
    assign rd_ok  = pop_evt & ~empty;
    assign mem_we = wr_ok & ~clr;

    always_comb begin
        rptr_nxt     = rptr_q;
        wptr_nxt     = wptr_q;
        level_nxt    = level_q;
        overrun_nxt  = overrun;
        underrun_nxt = underrun;
        if (clr) begin
            rptr_nxt     = '0;
            wptr_nxt     = '0;
            level_nxt    = '0;
            overrun_nxt  = 1'b0;
            underrun_nxt = 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_nxt = wptr_q + AW'(1);
            end
            if (rd_ok) begin
                rptr_nxt = rptr_q + AW'(1);
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   level_nxt = level_q + LW'(1);
                2'b01:   level_nxt = level_q - LW'(1);
                default: level_nxt = level_q;
            endcase
            if (push & full & ~pop_evt) begin
                overrun_nxt = 1'b1;
            end
            if (pop_evt & empty) begin
                underrun_nxt = 1'b1;
            end
        end
    end

    // pop_d keeps tracking pop through a flush so a held pop cannot re-trigger.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            level_q  <= '0;
            pop_d    <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            rptr_q   <= rptr_nxt;
            wptr_q   <= wptr_nxt;
            level_q  <= level_nxt;
            pop_d    <= pop;
            overrun  <= overrun_nxt;
            underrun <= underrun_nxt;
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wptr_q),
        .wdata (din),
        .raddr (rptr_q),
        .rdata (head)
    );

    assign dout = empty ? '0 : head;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_en = 1'b1;
    logic       clr = 1'b0;
    logic       push = 1'b0;
    logic [7:0] din = 8'h00;
    logic       pop = 1'b0;
    logic [3:0] thresh = 4'd0;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       below_thresh;
    logic       overrun;
    logic       underrun;

    int checks = 0;
    int failures = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_en      (fifo_en),
        .clr          (clr),
        .push         (push),
        .din          (din),
        .pop          (pop),
        .thresh       (thresh),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .level        (level),
        .below_thresh (below_thresh),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue plus sticky flags.
    logic [7:0] q[$];
    bit         m_pop_prev = 1'b0;
    bit         m_ovr = 1'b0;
    bit         m_und = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_pop_prev = 1'b0;
            m_ovr      = 1'b0;
            m_und      = 1'b0;
        end else begin
            bit evt, was_empty, was_full;
            int cap;
            evt        = pop && !m_pop_prev;
            m_pop_prev = pop;
            if (clr) begin
                q.delete();
                m_ovr = 1'b0;
                m_und = 1'b0;
            end else begin
                cap       = fifo_en ? DEPTH : 1;
                was_empty = (q.size() == 0);
                was_full  = (q.size() == cap);
                if (evt && was_empty) m_und = 1'b1;
                if (evt && !was_empty) void'(q.pop_front());
                if (push) begin
                    if (!was_full || evt) q.push_back(din);
                    else m_ovr = 1'b1;
                end
            end
        end
    end

    // Every cycle, away from the active edge, outputs must match the model.
    always @(negedge clk) begin
        int         n;
        int         cap;
        logic [7:0] hd;
        n   = q.size();
        cap = fifo_en ? DEPTH : 1;
        hd  = (n == 0) ? 8'h00 : q[0];
        chk("dout", 32'(dout), 32'(hd));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == cap));
        chk("level", 32'(level), 32'(n));
        chk("below_thresh", 32'(below_thresh), 32'(n <= int'(thresh)));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("underrun", 32'(underrun), 32'(m_und));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        push = 1'b1;
        din  = b;
        cyc();
        push = 1'b0;
    endtask

    task automatic pop_edge();
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        cyc();
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_below", 32'(below_thresh), 32'd1);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Single byte, then pop held for 20 cycles dequeues once.
        push_byte(8'hA5);
        chk("a5_empty", 32'(empty), 32'd0);
        chk("a5_dout", 32'(dout), 32'hA5);
        chk("a5_level", 32'(level), 32'd1);
        pop = 1'b1;
        repeat (20) cyc();
        chk("hold_level", 32'(level), 32'd0);
        chk("hold_empty", 32'(empty), 32'd1);
        chk("hold_dout", 32'(dout), 32'd0);
        chk("hold_underrun", 32'(underrun), 32'd0);
        pop = 1'b0;
        cyc();

        // Fill, overflow, drain in order.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_level", 32'(level), 32'd16);
        push_byte(8'h55);
        chk("ovf_overrun", 32'(overrun), 32'd1);
        chk("ovf_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk("drain_dout", 32'(dout), 32'(i));
            pop_edge();
        end
        chk("drain_empty", 32'(empty), 32'd1);
        clr_pulse();
        chk("clr_overrun", 32'(overrun), 32'd0);

        // Push and pop together on a full FIFO.
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        push = 1'b1;
        din  = 8'h77;
        pop  = 1'b1;
        cyc();
        push = 1'b0;
        pop  = 1'b0;
        chk("pp_level", 32'(level), 32'd16);
        chk("pp_overrun", 32'(overrun), 32'd0);
        chk("pp_head", 32'(dout), 32'h01);
        cyc();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("pp_last", 32'(dout), 32'h77);
            pop_edge();
        end
        chk("pp_empty", 32'(empty), 32'd1);

        // 16450 mode: single holding register.
        fifo_en = 1'b0;
        clr_pulse();
        push_byte(8'h11);
        chk("m0_full", 32'(full), 32'd1);
        chk("m0_level", 32'(level), 32'd1);
        push_byte(8'h22);
        chk("m0_overrun", 32'(overrun), 32'd1);
        chk("m0_dout", 32'(dout), 32'h11);
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        chk("m0_empty", 32'(empty), 32'd1);
        chk("m0_dout0", 32'(dout), 32'd0);
        cyc();
        fifo_en = 1'b1;
        clr_pulse();

        // Threshold flag, then clr with a simultaneous push.
        pop_edge();
        chk("und_set", 32'(underrun), 32'd1);
        thresh = 4'd4;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i));
        chk("th_below0", 32'(below_thresh), 32'd0);
        chk("th_level5", 32'(level), 32'd5);
        pop_edge();
        chk("th_below1", 32'(below_thresh), 32'd1);
        chk("th_level4", 32'(level), 32'd4);
        clr  = 1'b1;
        push = 1'b1;
        din  = 8'h99;
        cyc();
        clr  = 1'b0;
        push = 1'b0;
        chk("cp_level", 32'(level), 32'd0);
        chk("cp_empty", 32'(empty), 32'd1);
        chk("cp_underrun", 32'(underrun), 32'd0);
        chk("cp_overrun", 32'(overrun), 32'd0);

        // Asynchronous reset mid-cycle, released with pop held.
        for (int i = 0; i < 9; i++) push_byte(8'(8'h40 + i));
        chk("ar_level9", 32'(level), 32'd9);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("ar_empty", 32'(empty), 32'd1);
        chk("ar_level", 32'(level), 32'd0);
        chk("ar_dout", 32'(dout), 32'd0);
        pop = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        chk("ar_underrun", 32'(underrun), 32'd1);
        chk("ar_level0", 32'(level), 32'd0);
        repeat (3) cyc();
        pop = 1'b0;
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
